// File: rtl/vcore_cache_req_arb_pkg.sv
// Shared types for the vcore L2 request arbiter: arbitration mode, channel index
// and the cache request/response payloads carried through it.
package vcore_cache_req_arb_pkg;

   localparam int unsigned VCORE_ARB_MAX_CH = 8;

   typedef enum logic {
      VCORE_ARB_RR    = 1'b0,
      VCORE_ARB_FIXED = 1'b1
   } vcore_arb_mode_e;

   typedef logic [$clog2(VCORE_ARB_MAX_CH)-1:0] vcore_arb_ch_idx_t;

   // Cache port payloads shared by the core, AMO and vector requesters
   typedef struct packed {
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
      logic        we;
   } cpu_cache_if_req_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        err;
   } cpu_cache_if_resp_t;

endpackage

// File: rtl/vcore_tag_fifo.sv
// Synchronous FIFO holding the originating channel of each in-flight request.
// Pop on empty is ignored; push at full is accepted only alongside a pop.
module vcore_tag_fifo #(
   parameter int unsigned Width = 3,
   parameter int unsigned Depth = 8
) (
   input  logic                      clk,
   input  logic                      s2b_rst,
   input  logic                      push_i,
   input  logic [Width-1:0]          wdata_i,
   input  logic                      pop_i,
   output logic [Width-1:0]          rdata_o,
   output logic [$clog2(Depth):0]    count_o,
   output logic                      empty_o
);

   localparam int unsigned PtrW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PtrW:0]    count_q, count_d;
   logic             pop_eff, push_eff, full;

   // Next-state: pointers wrap naturally because Depth is a power of two
   always_comb begin
      full     = (count_q == Depth[PtrW:0]);
      pop_eff  = pop_i && (count_q != '0);
      push_eff = push_i && (!full || pop_eff);
      mem_d    = mem_q;
      if (push_eff) begin
         mem_d[wr_ptr_q] = wdata_i;
      end
      wr_ptr_d = wr_ptr_q + PtrW'(push_eff);
      rd_ptr_d = rd_ptr_q + PtrW'(pop_eff);
      count_d  = count_q + (PtrW+1)'(push_eff) - (PtrW+1)'(pop_eff);
   end

   // Pointer/count state with synchronous reset
   always_ff @(posedge clk) begin
      if (s2b_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read after being written
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/vcore_cache_req_arb.sv
// N-channel arbiter merging requesters onto the single L2 cache port. In-order
// responses are steered back to their originator through a tag FIFO.
module vcore_cache_req_arb
   import vcore_cache_req_arb_pkg::*;
#(
   parameter int unsigned NUM_CH    = 3,
   parameter int unsigned TAG_DEPTH = 8,
   parameter int unsigned ARB_MODE  = 0,
   parameter int unsigned OUT_REG   = 1
) (
   input  logic                            clk,
   input  logic                            s2b_rst,
   input  logic [NUM_CH-1:0]               ch_req_valid,
   input  cpu_cache_if_req_t [NUM_CH-1:0]  ch_req,
   input  logic [NUM_CH-1:0]               ch_req_expects_resp,
   output logic [NUM_CH-1:0]               ch_req_ready,
   output logic                            l2_req_valid,
   output cpu_cache_if_req_t               l2_req,
   input  logic                            l2_req_ready,
   input  logic                            l2_resp_valid,
   input  cpu_cache_if_resp_t              l2_resp,
   output logic                            l2_resp_ready,
   output logic [NUM_CH-1:0]               ch_resp_valid,
   output cpu_cache_if_resp_t              ch_resp,
   input  logic [NUM_CH-1:0]               ch_resp_ready,
   output logic [$clog2(TAG_DEPTH):0]      b2s_arb_outstanding,
   output logic                            b2s_arb_err
);

   localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;
   localparam vcore_arb_mode_e Mode = (ARB_MODE != 0) ? VCORE_ARB_FIXED : VCORE_ARB_RR;
   localparam logic [CntW:0] TagDepthC = TAG_DEPTH[CntW:0];

   logic                oreg_valid_q, oreg_valid_d, oreg_exp_q, oreg_exp_d;
   cpu_cache_if_req_t   oreg_req_q, oreg_req_d;
   vcore_arb_ch_idx_t   oreg_ch_q, oreg_ch_d;
   vcore_arb_ch_idx_t   rr_q, rr_d;
   logic                err_q, err_d;

   logic [NUM_CH-1:0]   eligible;
   logic                stage_free, pending_resp, tag_open, gnt_any, sel_exp, head_ready;
   logic [CntW:0]       tag_used;
   vcore_arb_ch_idx_t   gnt_idx;
   cpu_cache_if_req_t   sel_req;

   logic                fifo_push, fifo_pop, fifo_empty;
   vcore_arb_ch_idx_t   fifo_wdata, fifo_head;
   logic [CntW-1:0]     fifo_count;

   // Eligibility and grant selection; tag gate ignores a same-cycle pop
   always_comb begin
      stage_free   = (OUT_REG != 0) ? (!oreg_valid_q || l2_req_ready) : l2_req_ready;
      pending_resp = (OUT_REG != 0) && oreg_valid_q && oreg_exp_q;
      tag_used     = {1'b0, fifo_count} + {{CntW{1'b0}}, pending_resp};
      tag_open     = (tag_used < TagDepthC);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         eligible[i] = !s2b_rst && ch_req_valid[i] && stage_free &&
                       (!ch_req_expects_resp[i] || tag_open);
      end
      gnt_any = 1'b0;
      gnt_idx = '0;
      // Round-robin first searches rr..NUM_CH-1, then wraps to the lowest index
      if (Mode == VCORE_ARB_RR) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!gnt_any && eligible[i] && (vcore_arb_ch_idx_t'(i) >= rr_q)) begin
               gnt_any = 1'b1;
               gnt_idx = vcore_arb_ch_idx_t'(i);
            end
         end
      end
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!gnt_any && eligible[i]) begin
            gnt_any = 1'b1;
            gnt_idx = vcore_arb_ch_idx_t'(i);
         end
      end
      ch_req_ready = '0;
      sel_req      = '0;
      sel_exp      = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (gnt_idx == vcore_arb_ch_idx_t'(i)) begin
            ch_req_ready[i] = gnt_any;
            sel_req         = ch_req[i];
            sel_exp         = ch_req_expects_resp[i];
         end
      end
      rr_d = rr_q;
      if (gnt_any) begin
         rr_d = (gnt_idx == vcore_arb_ch_idx_t'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   // Output stage: registered or pass-through, plus tag push on the L2 handshake
   always_comb begin
      oreg_valid_d = oreg_valid_q;
      oreg_exp_d   = oreg_exp_q;
      oreg_req_d   = oreg_req_q;
      oreg_ch_d    = oreg_ch_q;
      if (l2_req_ready || (OUT_REG == 0)) begin
         oreg_valid_d = 1'b0;
      end
      if (gnt_any && (OUT_REG != 0)) begin
         oreg_valid_d = 1'b1;
         oreg_exp_d   = sel_exp;
         oreg_req_d   = sel_req;
         oreg_ch_d    = gnt_idx;
      end
      if (OUT_REG != 0) begin
         l2_req_valid = oreg_valid_q;
         l2_req       = oreg_req_q;
         fifo_push    = oreg_valid_q && l2_req_ready && oreg_exp_q;
         fifo_wdata   = oreg_ch_q;
      end else begin
         l2_req_valid = gnt_any;
         l2_req       = sel_req;
         fifo_push    = gnt_any && sel_exp && l2_req_ready;
         fifo_wdata   = gnt_idx;
      end
   end

   // Response steering to the FIFO head; orphans are absorbed and flagged
   always_comb begin
      ch_resp       = l2_resp;
      ch_resp_valid = '0;
      head_ready    = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (fifo_head == vcore_arb_ch_idx_t'(i)) begin
            ch_resp_valid[i] = l2_resp_valid && !fifo_empty;
            head_ready       = ch_resp_ready[i];
         end
      end
      l2_resp_ready = fifo_empty ? l2_resp_valid : head_ready;
      fifo_pop      = l2_resp_valid && head_ready && !fifo_empty;
      err_d         = err_q || (l2_resp_valid && fifo_empty);
   end

   // Arbiter state with synchronous reset
   always_ff @(posedge clk) begin
      if (s2b_rst) begin
         oreg_valid_q <= 1'b0;
         oreg_exp_q   <= 1'b0;
         oreg_req_q   <= '0;
         oreg_ch_q    <= '0;
         rr_q         <= '0;
         err_q        <= 1'b0;
      end else begin
         oreg_valid_q <= oreg_valid_d;
         oreg_exp_q   <= oreg_exp_d;
         oreg_req_q   <= oreg_req_d;
         oreg_ch_q    <= oreg_ch_d;
         rr_q         <= rr_d;
         err_q        <= err_d;
      end
   end

   vcore_tag_fifo #(
      .Width ($bits(vcore_arb_ch_idx_t)),
      .Depth (TAG_DEPTH)
   ) u_tag_fifo (
      .clk     (clk),
      .s2b_rst (s2b_rst),
      .push_i  (fifo_push),
      .wdata_i (fifo_wdata),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_head),
      .count_o (fifo_count),
      .empty_o (fifo_empty)
   );

   assign b2s_arb_outstanding = fifo_count;
   assign b2s_arb_err         = err_q;

endmodule
